// File: rtl/audio_avg_filter.sv
// audio_avg_filter: stereo moving average over the last 2^L sample pairs, with a bypass mode.
module audio_avg_filter #(
   parameter int L = 3,
   parameter int W = 24
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   input  logic [W-1:0] in_left,
   input  logic [W-1:0] in_right,
   output logic         in_ready,
   input  logic         enable,
   output logic         out_valid,
   output logic [W-1:0] out_left,
   output logic [W-1:0] out_right
);
   localparam int N = 1 << L;
   typedef enum logic [2:0] {CLEAR, IDLE, FETCH, ACC, OUT} state_t;
   state_t state, state_next;
   logic [L-1:0] ptr;
   logic signed [W-1:0] mem_l [N];
   logic signed [W-1:0] mem_r [N];
   logic signed [W-1:0] new_l, new_r, old_l, old_r;
   logic en;
   logic signed [W+L-1:0] sum_l, sum_r, sum_l_next, sum_r_next;
   assign sum_l_next = sum_l + {{L{new_l[W-1]}}, new_l} - {{L{old_l[W-1]}}, old_l};
   assign sum_r_next = sum_r + {{L{new_r[W-1]}}, new_r} - {{L{old_r[W-1]}}, old_r};
   always_ff @(posedge clk)
      if (reset) state <= CLEAR;
      else state <= state_next;
   always_comb begin
      state_next = state;
      in_ready = 1'b0;
      out_valid = 1'b0;
      case (state)
         CLEAR: state_next = (ptr == L'(N-1)) ? IDLE : CLEAR;
         IDLE: begin
            in_ready = 1'b1;
            state_next = in_valid ? FETCH : IDLE;
         end
         FETCH: state_next = ACC;
         ACC: state_next = OUT;
         OUT: begin
            out_valid = 1'b1;
            state_next = IDLE;
         end
         default: state_next = CLEAR;
      endcase
   end
   // Buffer and sum keep updating in bypass so re-enabling has no transient.
   always_ff @(posedge clk)
      if (reset) begin
         ptr <= '0;
         sum_l <= '0;
         sum_r <= '0;
         new_l <= '0;
         new_r <= '0;
         old_l <= '0;
         old_r <= '0;
         en <= 1'b0;
         out_left <= '0;
         out_right <= '0;
      end else
         case (state)
            CLEAR: begin
               mem_l[ptr] <= '0;
               mem_r[ptr] <= '0;
               ptr <= ptr + 1'b1;
            end
            IDLE:
               if (in_valid) begin
                  new_l <= in_left;
                  new_r <= in_right;
                  en <= enable;
               end
            FETCH: begin
               old_l <= mem_l[ptr];
               old_r <= mem_r[ptr];
            end
            ACC: begin
               sum_l <= sum_l_next;
               sum_r <= sum_r_next;
               mem_l[ptr] <= new_l;
               mem_r[ptr] <= new_r;
               ptr <= ptr + 1'b1;
               out_left <= en ? W'(sum_l_next >>> L) : new_l;
               out_right <= en ? W'(sum_r_next >>> L) : new_r;
            end
            default: ;
         endcase
endmodule

// File: tb/tb_audio_avg_filter.sv
// tb_audio_avg_filter: table vectors, corner sequences and random traffic against a queue-based mean model.
module tb_audio_avg_filter;
   logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0, enable = 1'b0;
   logic [23:0] in_left = '0, in_right = '0;
   logic in_ready, out_valid;
   logic [23:0] out_left, out_right;
   int n_cmp = 0, n_bad = 0;
   int hl[$], hr[$];
   typedef struct {
      logic [23:0] l, r;
      logic en;
      logic [23:0] el, er;
   } vec_t;
   vec_t tbl[$];

   audio_avg_filter #(.L(3), .W(24)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_left(in_left), .in_right(in_right),
      .in_ready(in_ready), .enable(enable), .out_valid(out_valid), .out_left(out_left), .out_right(out_right)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1);
   end

   task automatic check(input string name, input logic [23:0] got, input logic [23:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h required %h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int fmean(input int q[$]);
      longint s = 0;
      longint m;
      foreach (q[i]) s += q[i];
      m = s / 8;
      if (s < 0 && m * 8 != s) m -= 1;
      return int'(m);
   endfunction

   function automatic void model_reset();
      hl = {};
      hr = {};
      repeat (8) begin
         hl.push_back(0);
         hr.push_back(0);
      end
   endfunction

   task automatic do_reset();
      reset = 1'b1;
      in_valid = 1'b0;
      tick();
      check("reset_no_out_valid", 24'(out_valid), 24'd0);
      tick();
      reset = 1'b0;
      for (int k = 0; k <= 8; k++) begin
         check("clear_in_ready", 24'(in_ready), (k == 8) ? 24'd1 : 24'd0);
         check("clear_out_valid", 24'(out_valid), 24'd0);
         check("clear_out_left", out_left, 24'd0);
         check("clear_out_right", out_right, 24'd0);
         if (k < 8) tick();
      end
      model_reset();
   endtask

   task automatic xfer(input logic [23:0] l, input logic [23:0] r, input logic en,
                       output logic [23:0] gl, output logic [23:0] gr);
      int n, ml, mr;
      n = 0;
      while (!in_ready && n < 20) begin
         tick();
         n++;
      end
      check("ready_wait", 24'(in_ready), 24'd1);
      in_left = l;
      in_right = r;
      enable = en;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      enable = ~en;
      in_left = $urandom;
      in_right = $urandom;
      hl.push_back(int'($signed(l)));
      hr.push_back(int'($signed(r)));
      void'(hl.pop_front());
      void'(hr.pop_front());
      ml = en ? fmean(hl) : int'($signed(l));
      mr = en ? fmean(hr) : int'($signed(r));
      n = 0;
      while (!out_valid && n < 10) begin
         tick();
         n++;
      end
      check("latency", 24'(n), 24'd2);
      gl = out_left;
      gr = out_right;
      check("model_left", gl, ml[23:0]);
      check("model_right", gr, mr[23:0]);
      tick();
      check("pulse_len", 24'(out_valid), 24'd0);
      check("ready_again", 24'(in_ready), 24'd1);
   endtask

   initial begin
      logic [23:0] gl, gr, l, r;
      logic en;
      int prev, acc, outs, last, gap_bad, ml, mr;
      for (int k = 1; k <= 10; k++)
         tbl.push_back('{24'h010000, 24'h0, 1'b1, 24'((k < 8 ? k : 8) * 'h2000), 24'h0});
      for (int k = 1; k <= 8; k++)
         tbl.push_back('{24'h0, 24'h0, 1'b1, 24'((8 - k) * 'h2000), 24'h0});
      tbl.push_back('{24'hFFFFFF, 24'h0, 1'b1, 24'hFFFFFF, 24'h0});
      for (int k = 1; k <= 8; k++)
         tbl.push_back('{24'h0, 24'h0, 1'b1, (k < 8) ? 24'hFFFFFF : 24'h0, 24'h0});

      do_reset();
      foreach (tbl[i]) begin
         xfer(tbl[i].l, tbl[i].r, tbl[i].en, gl, gr);
         check("table_left", gl, tbl[i].el);
         check("table_right", gr, tbl[i].er);
      end

      for (int k = 0; k < 8; k++) xfer(24'h7FFFFF, 24'h800000, 1'b1, gl, gr);
      check("full_pos", gl, 24'h7FFFFF);
      check("full_neg", gr, 24'h800000);
      prev = int'($signed(gl));
      for (int k = 0; k < 8; k++) begin
         xfer(24'h800000, 24'h7FFFFF, 1'b1, gl, gr);
         check("descend_monotonic", 24'(int'($signed(gl)) <= prev), 24'd1);
         prev = int'($signed(gl));
      end
      check("full_bottom", gl, 24'h800000);
      check("full_top", gr, 24'h7FFFFF);

      for (int k = 0; k < 8; k++) begin
         l = 24'($urandom);
         r = 24'($urandom);
         xfer(l, r, 1'b0, gl, gr);
         check("bypass_left", gl, l);
         check("bypass_right", gr, r);
      end
      xfer(24'($urandom), 24'($urandom), 1'b1, gl, gr);

      for (int k = 0; k < 40; k++) begin
         l = 24'($urandom);
         r = 24'($urandom);
         en = 1'($urandom);
         xfer(l, r, en, gl, gr);
      end

      in_left = 24'h000400;
      in_right = 24'hFFFC00;
      enable = 1'b1;
      in_valid = 1'b1;
      acc = 0;
      outs = 0;
      last = -1;
      gap_bad = 0;
      for (int i = 0; i < 40; i++) begin
         if (in_ready) begin
            if (last >= 0 && i - last != 4) gap_bad++;
            last = i;
            acc++;
         end
         if (out_valid) outs++;
         if (i < 39) tick();
      end
      in_valid = 1'b0;
      repeat (10) begin
         hl.push_back(int'($signed(24'h000400)));
         hr.push_back(int'($signed(24'hFFFC00)));
         void'(hl.pop_front());
         void'(hr.pop_front());
      end
      ml = fmean(hl);
      mr = fmean(hr);
      check("stream_accepts", 24'(acc), 24'd10);
      check("stream_out_valids", 24'(outs), 24'd10);
      check("stream_gaps", 24'(gap_bad), 24'd0);
      check("stream_left", out_left, ml[23:0]);
      check("stream_right", out_right, mr[23:0]);
      tick();

      in_left = 24'h123456;
      in_right = 24'h654321;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      check("abort_in_acc", 24'(out_valid), 24'd0);
      do_reset();
      xfer(24'h000800, 24'h000800, 1'b1, gl, gr);
      check("after_abort_left", gl, 24'h000100);
      check("after_abort_right", gr, 24'h000100);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
